// File: rtl/lectura_rtc.sv
// lectura_rtc: RTC read sequencer capturing time, date and timer bytes into holding registers
module lectura_rtc #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicializado,
  input  logic       leer,
  input  logic       siga,
  input  logic       dato_valido,
  input  logic [7:0] dato_rd,
  output logic [7:0] Direc,
  output logic       lea,
  output logic       ocupado,
  output logic       listo,
  output logic       error,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] tseg,
  output logic [7:0] tmin,
  output logic [7:0] thora,
  output logic [2:0] auxiliar
);
  typedef enum logic [2:0] {REPOSO = 3'd0, ESPERA = 3'd1, PAUSA = 3'd2, FIN = 3'd3} state_t;
  state_t     st, st_n;
  logic [3:0] idx, idx_n;
  logic [7:0] cnt, cnt_n, direc_n;
  logic       lea_n, ocu_n, listo_n, err_n, cap;
  logic [7:0] h [9];
  function automatic logic [7:0] addr(input logic [3:0] i);
    return (i < 4'd6) ? 8'h21 + {4'd0, i} : 8'h3b + {4'd0, i};
  endfunction
  always_comb begin
    st_n    = st;
    idx_n   = idx;
    cnt_n   = cnt;
    direc_n = Direc;
    lea_n   = lea;
    ocu_n   = ocupado;
    listo_n = 1'b0;
    err_n   = error;
    cap     = 1'b0;
    case (st)
      REPOSO: begin
        direc_n = 8'h00;
        lea_n   = 1'b0;
        ocu_n   = 1'b0;
        if (leer && inicializado && !siga) begin
          idx_n   = 4'd0;
          direc_n = 8'h21;
          lea_n   = 1'b1;
          ocu_n   = 1'b1;
          cnt_n   = 8'd0;
          err_n   = 1'b0;
          st_n    = ESPERA;
        end
      end
      ESPERA: begin
        if (dato_valido) begin
          cap   = 1'b1;
          lea_n = 1'b0;
          st_n  = PAUSA;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          lea_n = 1'b0;
          ocu_n = 1'b0;
          err_n = 1'b1;
          st_n  = REPOSO;
        end else
          cnt_n = cnt + 8'd1;
      end
      PAUSA: begin
        lea_n = 1'b0;
        if (!siga) begin
          if (idx == 4'd8) begin
            listo_n = 1'b1;
            ocu_n   = 1'b0;
            direc_n = 8'h00;
            st_n    = FIN;
          end else begin
            idx_n   = idx + 4'd1;
            direc_n = addr(idx + 4'd1);
            lea_n   = 1'b1;
            cnt_n   = 8'd0;
            st_n    = ESPERA;
          end
        end
      end
      FIN: begin
        ocu_n   = 1'b0;
        direc_n = 8'h00;
        st_n    = REPOSO;
      end
      default: begin
        lea_n   = 1'b0;
        ocu_n   = 1'b0;
        direc_n = 8'h00;
        st_n    = REPOSO;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= REPOSO;
      idx     <= 4'd0;
      cnt     <= 8'd0;
      Direc   <= 8'h00;
      lea     <= 1'b0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
      error   <= 1'b0;
      for (int i = 0; i < 9; i++) h[i] <= 8'h00;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      Direc   <= direc_n;
      lea     <= lea_n;
      ocupado <= ocu_n;
      listo   <= listo_n;
      error   <= err_n;
      if (cap) h[idx] <= dato_rd;
    end
  end
  assign seg      = h[0];
  assign min      = h[1];
  assign hora     = h[2];
  assign dia      = h[3];
  assign mes      = h[4];
  assign anio     = h[5];
  assign tseg     = h[6];
  assign tmin     = h[7];
  assign thora    = h[8];
  assign auxiliar = st;
endmodule

// File: tb/tb_lectura_rtc.sv
// tb_lectura_rtc: directed self-checking bench for the RTC read sequencer
module tb_lectura_rtc;
  logic       clk = 0, reset = 1, inicializado = 0, leer = 0, siga = 0, dato_valido = 0;
  logic [7:0] dato_rd = 0;
  logic [7:0] Direc, seg, min, hora, dia, mes, anio, tseg, tmin, thora;
  logic       lea, ocupado, listo, error;
  logic [2:0] auxiliar;
  logic [7:0] got [9];
  logic [7:0] atab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  int n_chk = 0, n_fail = 0;
  int n, listo_cnt, listo_cyc, err_cyc, leafall, busy_bad;
  bit dbad, tmo_hit;
  logic [7:0] dlog [16];
  int rise [16];

  lectura_rtc #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .inicializado(inicializado), .leer(leer), .siga(siga),
    .dato_valido(dato_valido), .dato_rd(dato_rd), .Direc(Direc), .lea(lea), .ocupado(ocupado),
    .listo(listo), .error(error), .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes),
    .anio(anio), .tseg(tseg), .tmin(tmin), .thora(thora), .auxiliar(auxiliar)
  );

  always #5 clk = ~clk;
  always_comb got = '{seg, min, hora, dia, mes, anio, tseg, tmin, thora};

  task automatic drive_burst(input int busy, input logic [7:0] base, input int sidx, input int swait,
                             input bit stray, input int ridx);
    int c, bc, w;
    bit resp, lea_p, err_p;
    logic [7:0] dir_p;
    n = 0; listo_cnt = 0; listo_cyc = -1; err_cyc = -1; leafall = -1; busy_bad = 0;
    dbad = 0; tmo_hit = 0; bc = 0; resp = 0; lea_p = 0; err_p = error; dir_p = 0; c = 0;
    inicializado = 1; leer = 1;
    while (1) begin
      @(negedge clk); c++;
      if (c == 1) leer = 0;
      if (lea && !lea_p) begin dlog[n] = Direc; rise[n] = c; n++; end
      if (lea && lea_p && Direc !== dir_p) dbad = 1;
      if (!lea && lea_p) leafall = c;
      if (siga && lea) busy_bad++;
      if (listo) begin listo_cnt++; listo_cyc = c; end
      if (error && !err_p) err_cyc = c;
      lea_p = lea; err_p = error; dir_p = Direc;
      if (n > 0 && n - 1 == ridx && lea && rise[n-1] == c) begin reset = 1; break; end
      if (resp) begin siga = busy > 0; bc = busy > 0 ? busy - 1 : 0; end
      else if (bc > 0) bc--;
      else siga = 0;
      resp = 0; dato_valido = 0;
      if (lea && n > 0) begin
        w = (n - 1 == sidx) ? swait : 0;
        if (c - rise[n-1] == w) begin resp = 1; dato_valido = 1; dato_rd = base + 8'(n - 1); end
      end else if (stray && ocupado) begin dato_valido = 1; dato_rd = 8'hEE; end
      if (c >= 400) begin tmo_hit = 1; break; end
      if ((listo_cyc > 0 && c > listo_cyc) || err_cyc > 0) break;
    end
    dato_valido = 0; siga = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({Direc, lea, ocupado, listo, error, auxiliar} !== 15'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got Direc=%h lea=%b ocu=%b listo=%b err=%b aux=%0d want all 0", Direc, lea, ocupado, listo, error, auxiliar);
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== 8'h00) begin n_fail++; $display("FAIL reset_reg[%0d]: got %h want 00", i, got[i]); end
    end
    reset = 0;
  endtask

  task automatic test_gating;
    inicializado = 0; leer = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (lea !== 1'b0 || ocupado !== 1'b0) begin n_fail++; $display("FAIL gate_hold: got lea=%b ocu=%b want 0 0", lea, ocupado); end
    inicializado = 1;
    @(negedge clk);
    n_chk++;
    if ({lea, ocupado, Direc, auxiliar} !== {1'b1, 1'b1, 8'h21, 3'd1}) begin
      n_fail++; $display("FAIL gate_start: got lea=%b ocu=%b Direc=%h aux=%0d want 1 1 21 1", lea, ocupado, Direc, auxiliar);
    end
    leer = 0;
    repeat (8) @(negedge clk);
    n_chk++;
    if ({error, lea, ocupado, auxiliar, seg} !== {1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
      n_fail++; $display("FAIL gate_timeout: got err=%b lea=%b ocu=%b aux=%0d seg=%h want 1 0 0 0 00", error, lea, ocupado, auxiliar, seg);
    end
  endtask

  task automatic test_full_burst;
    drive_burst(0, 8'h10, 99, 0, 0, 99);
    n_chk++;
    if (tmo_hit || n !== 9) begin n_fail++; $display("FAIL full_reads: got %0d reads (budget=%b) want 9", n, tmo_hit); end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (dlog[i] !== atab[i] || rise[i] !== 1 + 2 * i) begin
        n_fail++; $display("FAIL full_addr[%0d]: got %h@%0d want %h@%0d", i, dlog[i], rise[i], atab[i], 1 + 2 * i);
      end
    end
    n_chk++;
    if (listo_cnt !== 1 || listo_cyc !== 19) begin n_fail++; $display("FAIL full_listo: got %0d pulses at %0d want 1 at 19", listo_cnt, listo_cyc); end
    n_chk++;
    if ({error, ocupado, dbad} !== 3'b000) begin n_fail++; $display("FAIL full_flags: got err=%b ocu=%b unstable=%b want 0 0 0", error, ocupado, dbad); end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL full_reg[%0d]: got %h want %h", i, got[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_busy;
    drive_burst(5, 8'h30, 99, 0, 0, 99);
    n_chk++;
    if (tmo_hit || n !== 9 || busy_bad !== 0) begin n_fail++; $display("FAIL busy_reads: got %0d reads, %0d lea-while-busy want 9, 0", n, busy_bad); end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (dlog[i] !== atab[i] || rise[i] !== 1 + 7 * i) begin
        n_fail++; $display("FAIL busy_addr[%0d]: got %h@%0d want %h@%0d", i, dlog[i], rise[i], atab[i], 1 + 7 * i);
      end
    end
    n_chk++;
    if (listo_cnt !== 1 || listo_cyc !== 64) begin n_fail++; $display("FAIL busy_listo: got %0d pulses at %0d want 1 at 64", listo_cnt, listo_cyc); end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== 8'h30 + 8'(i)) begin n_fail++; $display("FAIL busy_reg[%0d]: got %h want %h", i, got[i], 8'h30 + 8'(i)); end
    end
  endtask

  task automatic test_timeout;
    drive_burst(0, 8'h50, 3, -1, 0, 99);
    n_chk++;
    if (tmo_hit || n !== 4 || rise[3] !== 7) begin n_fail++; $display("FAIL tmo_reads: got %0d reads, last rise %0d want 4, 7", n, rise[3]); end
    n_chk++;
    if (leafall - rise[3] !== 8 || err_cyc !== leafall) begin
      n_fail++; $display("FAIL tmo_timing: got lea fall +%0d error at %0d want +8 at %0d", leafall - rise[3], err_cyc, leafall);
    end
    n_chk++;
    if ({error, lea, ocupado} !== 3'b100 || listo_cnt !== 0) begin
      n_fail++; $display("FAIL tmo_flags: got err=%b lea=%b ocu=%b listo=%0d want 1 0 0 0", error, lea, ocupado, listo_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== (i < 3 ? 8'h50 + 8'(i) : 8'h30 + 8'(i))) begin
        n_fail++; $display("FAIL tmo_reg[%0d]: got %h want %h", i, got[i], i < 3 ? 8'h50 + 8'(i) : 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_stray;
    dato_valido = 1; dato_rd = 8'hEE;
    repeat (2) @(negedge clk);
    dato_valido = 0;
    n_chk++;
    if ({seg, dia, error, auxiliar} !== {8'h50, 8'h33, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL stray_idle: got seg=%h dia=%h err=%b aux=%0d want 50 33 1 0", seg, dia, error, auxiliar);
    end
    drive_burst(0, 8'h80, 99, 0, 1, 99);
    n_chk++;
    if (listo_cnt !== 1 || listo_cyc !== 19 || error !== 1'b0) begin
      n_fail++; $display("FAIL stray_listo: got %0d pulses at %0d err=%b want 1 at 19 err 0", listo_cnt, listo_cyc, error);
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== 8'h80 + 8'(i)) begin n_fail++; $display("FAIL stray_reg[%0d]: got %h want %h", i, got[i], 8'h80 + 8'(i)); end
    end
  endtask

  task automatic test_overlap;
    drive_burst(0, 8'h60, 2, 7, 0, 99);
    n_chk++;
    if (tmo_hit || error !== 1'b0 || listo_cnt !== 1 || listo_cyc !== 26) begin
      n_fail++; $display("FAIL ovl_flags: got err=%b %0d pulses at %0d want err 0, 1 at 26", error, listo_cnt, listo_cyc);
    end
    n_chk++;
    if (rise[3] - rise[2] !== 9) begin n_fail++; $display("FAIL ovl_gap: got %0d want 9", rise[3] - rise[2]); end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== 8'h60 + 8'(i)) begin n_fail++; $display("FAIL ovl_reg[%0d]: got %h want %h", i, got[i], 8'h60 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid;
    drive_burst(0, 8'h90, 99, 0, 0, 4);
    n_chk++;
    if (n !== 5 || dlog[4] !== 8'h25 || seg !== 8'h90) begin
      n_fail++; $display("FAIL rmid_pre: got %0d reads Direc=%h seg=%h want 5 25 90", n, dlog[4], seg);
    end
    #1;
    n_chk++;
    if ({Direc, lea, ocupado, listo, error, auxiliar} !== 15'd0) begin
      n_fail++; $display("FAIL rmid_ctrl: got Direc=%h lea=%b ocu=%b listo=%b err=%b aux=%0d want all 0", Direc, lea, ocupado, listo, error, auxiliar);
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (got[i] !== 8'h00) begin n_fail++; $display("FAIL rmid_reg[%0d]: got %h want 00", i, got[i]); end
    end
    @(negedge clk);
    reset = 0;
    drive_burst(0, 8'hA0, 99, 0, 0, 99);
    n_chk++;
    if (dlog[0] !== 8'h21 || listo_cyc !== 19 || thora !== 8'hA8) begin
      n_fail++; $display("FAIL rmid_restart: got Direc=%h listo at %0d thora=%h want 21 19 a8", dlog[0], listo_cyc, thora);
    end
  endtask

  initial begin
    test_reset;
    test_gating;
    test_full_burst;
    test_busy;
    test_timeout;
    test_stray;
    test_overlap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
